gift_perm_engine: RTL and testbench
===================================

GIFT_PERM_ENGINE -- requirements
Module: gift_perm_engine

Interface
REQ-001 Parameter: WIDTH, default 128, state width in bits; legal values 64 (GIFT-64) or 128 (GIFT-128); any other value SHALL fail elaboration.
REQ-002 Parameter: RND_W, default 4, width of the round-count field.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  request present on in_data/in_inv/in_rounds.
REQ-006 Port: in_ready  output  1  engine can accept a request.
REQ-007 Port: in_data  input  WIDTH  state to permute.
REQ-008 Port: in_inv  input  1  0 = forward PermBits, 1 = inverse PermBits.
REQ-009 Port: in_rounds  input  RND_W  number k of permutation applications, 0..2^RND_W-1.
REQ-010 Port: out_valid  output  1  out_data holds a finished result.
REQ-011 Port: out_ready  input  1  consumer accepts out_data.
REQ-012 Port: out_data  output  WIDTH  P^k(in_data), or P^-k(in_data) when in_inv=1.
REQ-013 Port: busy  output  1  high in RUN and DONE.

Function
REQ-014 Forward map P: in bit i SHALL move to out bit P(i) = 4*floor(i/16) + (WIDTH/4)*((3*floor((i mod 16)/4) + (i mod 4)) mod 4) + (i mod 4), for i = 0..WIDTH-1.
REQ-015 Inverse map: out bit i = in bit P(i); P^-1(P(x)) = x for all x.
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-018 Accept: in IDLE with in_valid=1, load the state register with in_data, latch in_inv, and load the counter with in_rounds; go to DONE if in_rounds=0, otherwise go to RUN.
REQ-019 RUN: each cycle, state <= P(state), or P^-1(state) if the latched inv=1; counter decrements; the cycle with counter=1 applies the last round and moves to DONE.
REQ-020 Latency: out_valid SHALL rise exactly k+1 cycles after the accept cycle (k=0 -> next cycle).
REQ-021 DONE: out_data and out_valid SHALL hold stable while out_ready=0; on out_ready=1, go to IDLE next cycle.
REQ-022 No overlap: a request cannot be accepted in the same cycle as an output handshake; minimum request spacing is k+2 cycles.
REQ-023 Input changes while not in IDLE SHALL have no effect on the state register or the counter.
REQ-024 out_data SHALL equal the state register in every state; its value is don't-care outside DONE.
REQ-025 The data path SHALL contain one permutation network per direction (wiring only) and no multi-round unrolling.

Reset
REQ-026 rst=1 at a clock edge SHALL force state to IDLE, set the counter, the state register, and the latched inv to 0, and give in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-027 rst SHALL take priority over all handshakes in any state, including mid-RUN and in DONE with out_ready=1; a request in flight is discarded.

Verification
REQ-028 WIDTH=128, in_data=1<<1, inv=0, k=1 -> out_data=1<<33, out_valid 2 cycles after accept.
REQ-029 WIDTH=128, in_data=1<<1, inv=0, k=2 -> out_data=1<<41 after 3 cycles; with WIDTH=64, k=1 -> out_data=1<<17.
REQ-030 k=0, in_data=0x0123...CDEF (random) -> out_data=in_data, out_valid the cycle after accept.
REQ-031 Random x, forward k=15, then inverse k=15 on that result -> x restored; check against a reference model for all k in 0..15 in both directions.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, and in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-033 Assert rst in the 3rd RUN cycle of a k=8 job -> next cycle IDLE, out_valid=0, out_data=0; a new request then completes correctly.

Source files
------------

// File: rtl/gift_perm_engine.sv
// gift_perm_engine: iterates the GIFT PermBits layer (forward or inverse) k times on one state word.
module gift_perm_engine #(
    parameter int WIDTH = 128,
    parameter int RND_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    input  logic [RND_W-1:0] in_rounds,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    if (WIDTH != 64 && WIDTH != 128) begin : g_bad_width
        $error("gift_perm_engine: WIDTH must be 64 or 128");
    end

    state_t             st_q;
    logic [RND_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   data_q, data_d, fwd, bwd;
    logic               inv_q, in_ready_q, out_valid_q, busy_q;

    // Both directions are pure wiring of the same index map, one instance each.
    for (genvar i = 0; i < WIDTH; i++) begin : g_perm
        localparam int P = 4*(i/16) + (WIDTH/4)*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
        assign fwd[P] = data_q[i];
        assign bwd[i] = data_q[P];
    end

    always_comb data_d = inv_q ? bwd : fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (st_q)
                IDLE: if (in_valid) begin
                    data_q     <= in_data;
                    inv_q      <= in_inv;
                    cnt_q      <= in_rounds;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    if (in_rounds == '0) begin
                        st_q        <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        st_q <= RUN;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == RND_W'(1)) begin
                        st_q        <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    st_q        <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;
endmodule

// File: tb/tb_gift_perm_engine.sv
// tb_gift_perm_engine: directed vectors checked against a cycle-budget reference model of the engine.
module tb_gift_perm_engine;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [3:0]   in_rounds = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] out_data;

    logic         s_in_valid = 1'b0, s_in_inv = 1'b0, s_out_ready = 1'b0;
    logic [63:0]  s_in_data = '0;
    logic [3:0]   s_in_rounds = '0;
    logic         s_in_ready, s_out_valid, s_busy;
    logic [63:0]  s_out_data;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    gift_perm_engine #(.WIDTH(128), .RND_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .in_rounds(in_rounds), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    gift_perm_engine #(.WIDTH(64), .RND_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_inv(s_in_inv), .in_rounds(s_in_rounds), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .busy(s_busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pidx(input int i, input int w);
        return 4*(i/16) + (w/4)*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
    endfunction

    function automatic logic [127:0] perm(input logic [127:0] x, input bit inv, input int k, input int w);
        logic [127:0] y;
        for (int r = 0; r < k; r++) begin
            y = '0;
            for (int i = 0; i < w; i++) begin
                if (!inv) y[pidx(i, w)] = x[i];
                else      y[i] = x[pidx(i, w)];
            end
            x = y;
        end
        return x;
    endfunction

    // Model: a job accepted at cycle c with k rounds is due at cycle c+k+1 and lasts until handshaken.
    int           cyc = 0;
    int           m_due = 0;
    bit           m_init = 0, m_job = 0, m_zero = 0;
    logic [127:0] m_res = '0;

    always begin
        @(posedge clk);
        if (rst) begin
            m_init = 1;
            m_job  = 0;
            m_zero = 1;
        end else if (m_init) begin
            if (m_job) begin
                if (cyc >= m_due && out_ready) m_job = 0;
            end else if (in_valid) begin
                m_job  = 1;
                m_zero = 0;
                m_due  = cyc + int'(in_rounds) + 1;
                m_res  = perm(in_data, in_inv, int'(in_rounds), W);
            end
        end
        cyc++;
        #1;
        if (m_init) begin
            chk("in_ready", in_ready, !m_job);
            chk("out_valid", out_valid, m_job && cyc >= m_due);
            chk("busy", busy, m_job);
            if (m_job && cyc >= m_due) chk("out_data", out_data, m_res);
            else if (m_zero) chk("out_data_zero", out_data, '0);
        end
    end

    task automatic start(input logic [127:0] d, input bit inv, input logic [3:0] k);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            errs++;
            $display("FAIL start_timeout: in_ready still 0 after %0d cycles", n);
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_inv    = inv;
        in_rounds = k;
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        in_inv    = ~inv;
        in_rounds = 4'($urandom);
    endtask

    task automatic finish(output logic [127:0] res, output int lat);
        int n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            vectors++;
            errs++;
            $display("FAIL valid_timeout: out_valid still 0 after %0d cycles", n);
        end
        lat = n;
        res = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] x, r1, r2, held;
        int lat, n;
        chk("model_k1", perm(128'h2, 0, 1, 128), 128'h1 << 33);
        chk("model_k2", perm(128'h2, 0, 2, 128), 128'h1 << 41);
        chk("model_w64", perm(128'h2, 0, 1, 64), 128'h1 << 17);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, '0);

        start(128'h2, 0, 4'd1);
        finish(r1, lat);
        chk("k1_data", r1, 128'h1 << 33);
        chk("k1_latency", lat, 2);

        start(128'h2, 0, 4'd2);
        finish(r1, lat);
        chk("k2_data", r1, 128'h1 << 41);
        chk("k2_latency", lat, 3);

        x = 128'h0123456789ABCDEF0123456789ABCDEF;
        start(x, 0, 4'd0);
        finish(r1, lat);
        chk("k0_data", r1, x);
        chk("k0_latency", lat, 1);

        s_in_valid = 1'b1; s_in_data = 64'h2; s_in_inv = 1'b0; s_in_rounds = 4'd1;
        @(negedge clk);
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w64_valid", s_out_valid, 1'b1);
        chk("w64_data", s_out_data, 64'h1 << 17);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("w64_idle", s_in_ready, 1'b1);

        for (int k = 0; k < 16; k++) begin
            for (int v = 0; v < 2; v++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                start(x, v[0], k[3:0]);
                finish(r1, lat);
                chk("sweep_latency", lat, k + 1);
            end
        end

        x = {$urandom, $urandom, $urandom, $urandom};
        start(x, 0, 4'd15);
        finish(r1, lat);
        start(r1, 1, 4'd15);
        finish(r2, lat);
        chk("roundtrip", r2, x);

        x = {$urandom, $urandom, $urandom, $urandom};
        start(x, 1, 4'd3);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("hold_data", out_data, held);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release", in_ready, 1'b1);

        start({$urandom, $urandom, $urandom, $urandom}, 0, 4'd8);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_ready", in_ready, 1'b1);
        chk("midrun_rst_valid", out_valid, 1'b0);
        chk("midrun_rst_data", out_data, '0);
        start(128'h2, 0, 4'd2);
        finish(r1, lat);
        chk("post_rst_data", r1, 128'h1 << 41);
        chk("post_rst_latency", lat, 3);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
